// File: rtl/act_buf_pkg.sv
// Shared definitions for the ping-pong activation buffer: row geometry and the packed row type.
// A row holds three 8-bit activations, with row0 in the lowest byte.
package act_buf_pkg;

    localparam int DATA_W   = 24;
    localparam int ROW_W    = 8;
    localparam int ROW0_LSB = 0;
    localparam int ROW1_LSB = 8;
    localparam int ROW2_LSB = 16;

    typedef logic [2:0][ROW_W-1:0] act_row_t;

    function automatic act_row_t pack_row(
        input logic [ROW_W-1:0] a0,
        input logic [ROW_W-1:0] a1,
        input logic [ROW_W-1:0] a2
    );
        act_row_t row;
        row[0] = a0;
        row[1] = a1;
        row[2] = a2;
        return row;
    endfunction

endpackage

// File: rtl/act_bank_fifo.sv
// Single activation bank: a DEPTH-entry synchronous FIFO with a show-ahead head.
// flush returns both pointers and the count to zero without touching storage.
module act_bank_fifo #(
    parameter int DATA_W = 24,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data,
    output logic [CNT_W-1:0]  count,
    output logic [DATA_W-1:0] head
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              w_push;
    logic              w_pop;

    assign w_push = push && (r_count != CNT_W'(DEPTH));
    assign w_pop  = pop && (r_count != '0);

    // NOTE: storage is deliberately left out of reset; an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data;
        end
    end

    // NOTE: every state register here is assigned with <= so all banks see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign count = r_count;
    assign head  = (r_count == '0) ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/act_pingpong_buffer.sv
// Ping-pong activation store: one bank is filled while the other feeds the systolic array.
// A swap is only granted once the read bank drains, so no row is ever lost across a layer change.
module act_pingpong_buffer #(
    parameter int DATA_W = act_buf_pkg::DATA_W,
    parameter int DEPTH  = 8,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_valid,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              swap,
    output logic              swap_done,
    output logic              swap_err,
    output logic              rd_bank,
    output logic [CNT_W-1:0]  rd_count,
    output logic [CNT_W-1:0]  wr_count
);

    logic              r_rd_bank;
    logic              r_swap_done;
    logic              r_swap_err;
    logic [CNT_W-1:0]  w_count [2];
    logic [DATA_W-1:0] w_head  [2];
    logic [1:0]        w_push;
    logic [1:0]        w_pop;
    logic [1:0]        w_flush;
    logic              w_push_fire;
    logic              w_pop_fire;
    logic              w_swap_ok;
    logic              w_swap_accept;
    logic              w_swap_reject;

    assign rd_count = w_count[r_rd_bank];
    assign wr_count = w_count[~r_rd_bank];
    assign rd_data  = w_head[r_rd_bank];
    assign wr_ready = (wr_count != CNT_W'(DEPTH));
    assign rd_valid = (rd_count != '0);

    assign w_push_fire = wr_valid && wr_ready;
    assign w_pop_fire  = rd_ready && rd_valid;

    // The read bank must be empty once this cycle's pop has been taken into account.
    assign w_swap_ok     = (rd_count == '0) || ((rd_count == CNT_W'(1)) && w_pop_fire);
    assign w_swap_accept = swap && !clear && w_swap_ok;
    assign w_swap_reject = swap && !clear && !w_swap_ok;

    // Push and pop follow the pre-swap roles; the drained bank is flushed as it becomes the write bank.
    assign w_push[0]  = w_push_fire && r_rd_bank;
    assign w_push[1]  = w_push_fire && !r_rd_bank;
    assign w_pop[0]   = w_pop_fire && !r_rd_bank;
    assign w_pop[1]   = w_pop_fire && r_rd_bank;
    assign w_flush[0] = clear || (w_swap_accept && !r_rd_bank);
    assign w_flush[1] = clear || (w_swap_accept && r_rd_bank);

    for (genvar b = 0; b < 2; b++) begin : g_bank
        act_bank_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_bank (
            .clk   (clk),
            .rst   (rst),
            .flush (w_flush[b]),
            .push  (w_push[b]),
            .pop   (w_pop[b]),
            .data  (wr_data),
            .count (w_count[b]),
            .head  (w_head[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank   <= 1'b0;
            r_swap_done <= 1'b0;
            r_swap_err  <= 1'b0;
        end else begin
            r_swap_done <= w_swap_accept;
            r_swap_err  <= w_swap_reject;
            if (w_swap_accept) begin
                r_rd_bank <= ~r_rd_bank;
            end
        end
    end

    assign rd_bank   = r_rd_bank;
    assign swap_done = r_swap_done;
    assign swap_err  = r_swap_err;

endmodule

// File: tb/tb_act_pingpong_buffer.sv
// Self-checking bench for act_pingpong_buffer: a role-based queue model predicts every row,
// pulse and count, one scenario task per feature.
module tb_act_pingpong_buffer;
    import act_buf_pkg::*;

    localparam int DEPTH = 8;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst;
    logic             clear;
    logic             wr_valid;
    logic [23:0]      wr_data;
    logic             wr_ready;
    logic             rd_ready;
    logic             rd_valid;
    logic [23:0]      rd_data;
    logic             swap;
    logic             swap_done;
    logic             swap_err;
    logic             rd_bank;
    logic [CNT_W-1:0] rd_count;
    logic [CNT_W-1:0] wr_count;

    int n_vec = 0;
    int n_err = 0;

    logic [23:0] rq[$];
    logic [23:0] wq[$];
    logic        m_rd_bank = 1'b0;

    always #5 clk = ~clk;

    act_pingpong_buffer #(
        .DATA_W (24),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_ready  (rd_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .swap      (swap),
        .swap_done (swap_done),
        .swap_err  (swap_err),
        .rd_bank   (rd_bank),
        .rd_count  (rd_count),
        .wr_count  (wr_count)
    );

    // One clock of stimulus: checks the show-ahead head, updates the model, then checks all outputs.
    task automatic step(input string tag, input logic r, input logic wv, input logic [23:0] wd,
                        input logic rr, input logic sw, input logic cl);
        logic        pop_ok;
        logic        push_ok;
        logic        swap_ok;
        logic        exp_done;
        logic        exp_err;
        logic [23:0] exp_head;
        rst      = r;
        wr_valid = wv;
        wr_data  = wd;
        rd_ready = rr;
        swap     = sw;
        clear    = cl;
        exp_head = (rq.size() != 0) ? rq[0] : 24'h0;
        n_vec++;
        if (rd_data !== exp_head) begin
            n_err++;
            $display("FAIL %s rd_data: got %h expected %h", tag, rd_data, exp_head);
        end
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (r) begin
            rq.delete();
            wq.delete();
            m_rd_bank = 1'b0;
        end else if (cl) begin
            rq.delete();
            wq.delete();
        end else begin
            pop_ok  = rr && (rq.size() != 0);
            push_ok = wv && (wq.size() < DEPTH);
            swap_ok = sw && (rq.size() == (pop_ok ? 1 : 0));
            if (pop_ok) void'(rq.pop_front());
            if (push_ok) wq.push_back(wd);
            if (swap_ok) begin
                rq = wq;
                wq.delete();
                m_rd_bank = ~m_rd_bank;
            end
            exp_done = swap_ok;
            exp_err  = sw && !swap_ok;
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_vec++;
        if (swap_done !== exp_done) begin
            n_err++;
            $display("FAIL %s swap_done: got %b expected %b", tag, swap_done, exp_done);
        end
        n_vec++;
        if (swap_err !== exp_err) begin
            n_err++;
            $display("FAIL %s swap_err: got %b expected %b", tag, swap_err, exp_err);
        end
        n_vec++;
        if (rd_bank !== m_rd_bank) begin
            n_err++;
            $display("FAIL %s rd_bank: got %b expected %b", tag, rd_bank, m_rd_bank);
        end
        n_vec++;
        if (rd_count !== CNT_W'(rq.size()) || wr_count !== CNT_W'(wq.size())) begin
            n_err++;
            $display("FAIL %s counts: got rd=%0d wr=%0d expected rd=%0d wr=%0d",
                     tag, rd_count, wr_count, rq.size(), wq.size());
        end
        n_vec++;
        if (rd_valid !== (rq.size() != 0) || wr_ready !== (wq.size() != DEPTH)) begin
            n_err++;
            $display("FAIL %s flags: got rd_valid=%b wr_ready=%b expected %b %b",
                     tag, rd_valid, wr_ready, rq.size() != 0, wq.size() != DEPTH);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; clear = 1'b0; wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0; swap = 1'b0;
        @(posedge clk);
        #1;
        step("reset_swap", 1'b1, 1'b1, 24'hFFFFFF, 1'b1, 1'b1, 1'b0);
        step("reset_idle", 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state: got rd_valid=%b wr_ready=%b rd_bank=%b expected 0 1 0",
                     rd_valid, wr_ready, rd_bank);
        end
    endtask

    task automatic test_basic();
        act_row_t rows [3];
        rows[0] = pack_row(8'h01, 8'h02, 8'h03);
        rows[1] = pack_row(8'h04, 8'h05, 8'h06);
        rows[2] = pack_row(8'h07, 8'h08, 8'h09);
        for (int i = 0; i < 3; i++) step("basic_push", 1'b0, 1'b1, rows[i], 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (wr_count !== CNT_W'(3) || rd_valid !== 1'b0) begin
            n_err++;
            $display("FAIL basic_fill: got wr_count=%0d rd_valid=%b expected 3 0", wr_count, rd_valid);
        end
        step("basic_swap", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (swap_done !== 1'b1 || rd_bank !== 1'b1 || rd_data !== 24'h030201) begin
            n_err++;
            $display("FAIL basic_after_swap: got done=%b bank=%b data=%h expected 1 1 030201",
                     swap_done, rd_bank, rd_data);
        end
        for (int i = 0; i < 3; i++) step("basic_pop", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_full();
        logic seen_bad = 1'b0;
        for (int i = 0; i < DEPTH; i++)
            step("full_push", 1'b0, 1'b1, 24'(32'h00A000 + i), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (wr_ready !== 1'b0) begin
            n_err++;
            $display("FAIL full_wr_ready: got %b expected 0", wr_ready);
        end
        step("full_drop", 1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (wr_count !== CNT_W'(DEPTH)) begin
            n_err++;
            $display("FAIL full_drop_count: got %0d expected %0d", wr_count, DEPTH);
        end
        step("full_swap", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            if (rd_data === 24'hFFFFFF) seen_bad = 1'b1;
            step("full_drain", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        end
        n_vec++;
        if (seen_bad !== 1'b0) begin
            n_err++;
            $display("FAIL full_no_dropped_row: got seen=%b expected 0", seen_bad);
        end
    endtask

    task automatic test_swap_rules();
        step("rule_push", 1'b0, 1'b1, 24'h111111, 1'b0, 1'b0, 1'b0);
        step("rule_push", 1'b0, 1'b1, 24'h222222, 1'b0, 1'b0, 1'b0);
        step("rule_swap_empty", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        step("rule_swap_busy", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        n_vec++;
        if (swap_err !== 1'b1 || rd_bank !== 1'b1 || rd_count !== CNT_W'(2)) begin
            n_err++;
            $display("FAIL rule_reject: got err=%b bank=%b rd_count=%0d expected 1 1 2",
                     swap_err, rd_bank, rd_count);
        end
        step("rule_pop", 1'b0, 1'b0, 24'h0, 1'b1, 1'b0, 1'b0);
        step("rule_swap_last_pop", 1'b0, 1'b0, 24'h0, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (swap_done !== 1'b1 || rd_bank !== 1'b0) begin
            n_err++;
            $display("FAIL rule_accept_on_pop: got done=%b bank=%b expected 1 0", swap_done, rd_bank);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < DEPTH; i++)
            step("b2b_prefill", 1'b0, 1'b1, 24'(32'h00B000 + i), 1'b0, 1'b0, 1'b0);
        step("b2b_swap", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step("b2b_stream", 1'b0, 1'b1, 24'(32'h00C000 + i), 1'b1, rq.size() == 1, 1'b0);
            n_vec++;
            if (int'(rd_count) + int'(wr_count) != DEPTH) begin
                n_err++;
                $display("FAIL b2b_total: got %0d expected %0d", int'(rd_count) + int'(wr_count), DEPTH);
            end
        end
        for (int i = 0; i < DEPTH; i++)
            step("b2b_drain", 1'b0, 1'b0, 24'h0, 1'b1, rq.size() == 1, 1'b0);
    endtask

    task automatic test_clear();
        logic bank_before;
        for (int i = 0; i < 3; i++) step("clr_pre", 1'b0, 1'b1, 24'(32'h00D000 + i), 1'b0, 1'b0, 1'b0);
        step("clr_swap", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step("clr_fill", 1'b0, 1'b1, 24'(32'h00E000 + i), 1'b0, 1'b0, 1'b0);
        bank_before = rd_bank;
        step("clr_hit", 1'b0, 1'b1, 24'h00EEEE, 1'b1, 1'b1, 1'b1);
        n_vec++;
        if (rd_count !== '0 || wr_count !== '0 || swap_done !== 1'b0 || swap_err !== 1'b0
            || rd_bank !== bank_before) begin
            n_err++;
            $display("FAIL clear_effect: got rd=%0d wr=%0d done=%b err=%b bank=%b expected 0 0 0 0 %b",
                     rd_count, wr_count, swap_done, swap_err, rd_bank, bank_before);
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) step("mid_pre", 1'b0, 1'b1, 24'(32'h00F000 + i), 1'b0, 1'b0, 1'b0);
        step("mid_swap", 1'b0, 1'b0, 24'h0, 1'b0, 1'b1, 1'b0);
        step("mid_push", 1'b0, 1'b1, 24'h00F100, 1'b1, 1'b0, 1'b0);
        step("mid_push", 1'b0, 1'b1, 24'h00F101, 1'b0, 1'b0, 1'b0);
        step("mid_rst", 1'b1, 1'b1, 24'h00F102, 1'b1, 1'b1, 1'b0);
        n_vec++;
        if (rd_valid !== 1'b0 || wr_ready !== 1'b1 || rd_bank !== 1'b0 || rd_count !== '0
            || wr_count !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state: got rd_valid=%b wr_ready=%b bank=%b rd=%0d wr=%0d expected 0 1 0 0 0",
                     rd_valid, wr_ready, rd_bank, rd_count, wr_count);
        end
        step("mid_idle", 1'b0, 1'b0, 24'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_swap_rules();
        test_back_to_back();
        test_clear();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/act_pingpong_buffer.md
Name: act_pingpong_buffer

Overview:
- Double-buffered (ping-pong) activation store for the 3x3 MLP datapath; replaces the UB A/B pair and the buffer_select mux in front of the systolic array.
- Write side takes packed 3x8-bit rows from the initial-activation loader or the activation-pipeline refill repacker.
- Read side presents rows to the row0/row1/row2 skew path during COMPUTE.
- The layer controller issues a swap between layers so the refilled bank becomes the next layer's input.

Parameters:
- DATA_W, 24, row width (3 x 8-bit activations; row0 in [7:0], row1 in [15:8], row2 in [23:16]).
- DEPTH, 8, entries per bank; must be a power of two, >= 2.
- CNT_W, $clog2(DEPTH)+1, occupancy counter width.

Ports:
- clk  in  1  clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- clear  in  1  one-cycle pulse; empties both banks.
- wr_valid  in  1  write request into the write bank.
- wr_data  in  DATA_W  row to write.
- wr_ready  out  1  write bank not full.
- rd_ready  in  1  consumer pops head of the read bank.
- rd_valid  out  1  read bank not empty.
- rd_data  out  DATA_W  head of the read bank (show-ahead).
- swap  in  1  one-cycle request to exchange bank roles.
- swap_done  out  1  registered pulse; swap accepted.
- swap_err  out  1  registered pulse; swap rejected.
- rd_bank  out  1  bank currently on the read side (the write side is ~rd_bank).
- rd_count  out  CNT_W  read-bank occupancy.
- wr_count  out  CNT_W  write-bank occupancy.

Behaviour:
- Storage: two banks of DEPTH x DATA_W registers. Each bank has its own wr_ptr, rd_ptr and count.
  - Pointers are ADDR_W = $clog2(DEPTH) bits and wrap modulo DEPTH.
  - Count range is 0..DEPTH.
- Reset (rst=1 at an edge):
  - all pointers and counts = 0; rd_bank = 0;
  - swap_done = 0, swap_err = 0;
  - hence rd_valid = 0 and wr_ready = 1.
  - Memory contents are not reset.
  - Reset mid-operation discards all data. A swap pending in that cycle is ignored and produces no pulse.
- Write: the push fires when wr_valid && wr_ready.
  - The entry is stored at the write bank's wr_ptr; wr_ptr and wr_count increment at the edge.
  - A write while full is dropped; the count is unchanged.
- Read: rd_data = read bank mem[rd_ptr], combinational from registers (zero-latency show-ahead).
  - rd_data is 0 when the read bank is empty.
  - The pop fires when rd_ready && rd_valid; rd_ptr advances and rd_count decrements.
  - A pop while empty is ignored.
- Independence: push and pop in the same cycle touch different banks and never interact.
- Swap:
  - Accepted only when the read-bank count is 0 after this cycle's pop. That is, rd_count == 0, or rd_count == 1 with a pop firing.
  - On accept, rd_bank toggles at the edge and swap_done pulses in the next cycle. The old write bank, including a push landing in the same cycle, becomes the read bank. The drained bank becomes the write bank with its pointers reset to 0.
  - Otherwise no state changes and swap_err pulses for one cycle.
  - After an accepted swap, rd_valid is visible the cycle after the edge if the new read bank is non-empty.
- clear has priority over push, pop and swap in the same cycle.
  - All pointers and counts go to 0; rd_bank is unchanged; no swap pulse is generated.
- Priority: rst > clear > swap evaluation > push/pop.
  - Push and pop are evaluated against pre-swap bank roles.
- Status outputs: rd_count and wr_count are registered counts, remapped combinationally by rd_bank.
  - wr_ready = (wr_count != DEPTH); rd_valid = (rd_count != 0).
- Throughput: one push and one pop per cycle sustained.

Decomposition:
- Shared package act_buf_pkg:
  - DATA_W and row slice constants (ROW0_LSB = 0, ROW1_LSB = 8, ROW2_LSB = 16);
  - typedef act_row_t, a packed 3 x logic [7:0].
- One natural sub-module: act_bank_fifo, a single-bank synchronous FIFO.
  - Ports: push, pop, flush, data, count, head.
  - Instantiated twice; the top adds role muxing and swap control.

Test Plan:
- After reset, push 3 rows (0x030201, 0x060504, 0x090807) -> wr_count = 3, rd_valid = 0; swap -> swap_done next cycle, rd_bank = 1, rd_valid = 1, rd_data = 0x030201; three pops yield the rows in order, then rd_valid = 0.
- Fill the write bank with DEPTH = 8 rows -> wr_ready = 0 on the 8th; a 9th push (0xFFFFFF) is dropped, wr_count stays 8; the read-out after swap contains no 0xFFFFFF.
- Swap with rd_count = 2 and no pop -> swap_err pulse, rd_bank unchanged; swap in the cycle of the final pop (rd_count = 1, rd_ready = 1) -> accepted, swap_done.
- Simultaneous push and pop across banks for 20 cycles with wrap-around -> data order preserved per bank; counts constant.
- Assert clear together with push and swap at wr_count = 5 -> both counts 0, no swap_done or swap_err, rd_bank unchanged.
- Assert rst mid-stream with both banks partly full -> next cycle rd_valid = 0, wr_ready = 1, rd_bank = 0, both counts 0.
